vlogic_pipe: RTL and testbench
==============================

Name: vlogic_pipe

Overview:
Parametrised successor to the vector AND/OR/XOR lane.
- Performs the eight bitwise vector-logic ops on DATA_WIDTH-bit register slices.
- Adds per-element v0 masking (SEW-aware), mask-undisturbed/agnostic fill, configurable pipeline depth and ready/valid backpressure.
- Sits in the vALU beside the arithmetic lanes and feeds the shared writeback arbiter, which may stall it.

Parameters:
DATA_WIDTH, 64, slice width in bits; multiple of 64.
ADDR_WIDTH, 32, destination address/tag width.
LATENCY, 6, accept-to-output cycles with no stall; legal range 2..16.
OPSEL_WIDTH, 3, op select width.
MASK_ENABLE, 1, 0 removes v0 masking and ops 000/100-111; in_vm is then treated as 1.
SIDEBAND_ENABLE, 1, 0 ties out_sca/out_w_reg/out_mask to 0.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid & in_ready
in_addr  in  ADDR_WIDTH  destination tag
in_vec0  in  DATA_WIDTH  operand vs2
in_vec1  in  DATA_WIDTH  operand vs1 / broadcast scalar
in_vd_old  in  DATA_WIDTH  prior destination contents
in_v0  in  DATA_WIDTH/8  mask bits; bit i = element i
in_opSel  in  OPSEL_WIDTH  000 andn, 001 and, 010 or, 011 xor, 100 orn, 101 nand, 110 nor, 111 xnor
in_sew  in  2  00=8b, 01=16b, 10=32b, 11=64b
in_vm  in  1  1 = unmasked
in_ma  in  1  mask-agnostic: inactive elements become all-ones
in_sca, in_w_reg, in_mask  in  1 each  sideband flags
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_vec  out  DATA_WIDTH  result
out_addr  out  ADDR_WIDTH  tag
out_sca, out_w_reg, out_mask  out  1 each  delayed flags

Behaviour:
- Reset: all pipeline registers cleared.
  - out_valid, out_vec, out_addr and the flags read 0.
  - in_ready is 1 in the cycle after reset is released.
- Reset mid-operation discards all in-flight entries. No output is produced for them.
- Pipeline: LATENCY register stages with a global stall.
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall, combinational.
  - While stall is high, no stage advances and every output holds its value.
- Stage 0 captures operands on an accepted request. A non-accepted cycle inserts a bubble: valid 0, data/addr/flags 0.
- Stage 1 computes the raw op result and the byte mask.
- Byte mask: element i covers bytes [i*E, i*E+E-1], where E = 1<<in_sew bytes.
  - Element active iff in_vm | in_v0[i].
  - Only in_v0 bits 0 .. DATA_WIDTH/(8E)-1 are used.
- Merge, per byte:
  - Active byte: op result.
  - Inactive byte with ma=0: in_vd_old.
  - Inactive byte with ma=1: 8'hFF.
- in_mask=1 (mask-register op, e.g. vmand.mm): masking is bypassed and the full-width op result is written.
- Stages 2..LATENCY-1 are pure delay. Result, addr and flags stay aligned with valid.
- Throughput: one result per cycle when out_ready is held high.
- The flags are ANDed with the accepted valid at stage 0.
- Simultaneous pop and push while the output is full: the pipeline advances. No stall bubble is created, and no data is lost or duplicated.
- out_ready is ignored when out_valid=0. Bubbles never stall.
- in_opSel values outside the enabled set (MASK_ENABLE=0) produce 0.

Decomposition:
- Package vlogic_pkg:
  - op encoding localparams (OP_ANDN..OP_XNOR);
  - SEW encodings;
  - function sew_bytes(sew);
  - pipeline-entry struct {valid, addr, vec, sca, w_reg, mask}.
- Sub-module vlogic_mask_expand: combinational; in_v0, in_sew, in_vm → DATA_WIDTH/8 byte-enable vector.
- Top module: op case, merge, stall-able shift pipeline.

Test Plan:
- Unmasked and: vec0=64'hF0F0_F0F0_F0F0_F0F0, vec1=64'hFF00_FF00_FF00_FF00, op=001, vm=1 → out_vec=64'hF000_F000_F000_F000 exactly LATENCY cycles later, out_addr equal to in_addr.
- SEW=16, masked or: vm=0, v0=4'b0101, ma=0, vd_old=64'h1111_2222_3333_4444, vec0=0, vec1=64'hAAAA_BBBB_CCCC_DDDD, op=010 → 64'h1111_BBBB_3333_DDDD. The same request with ma=1 → 64'hFFFF_BBBB_FFFF_DDDD.
- Backpressure: stream 8 back-to-back requests with addr=1..8 and hold out_ready=0 for 3 cycles mid-stream → in_ready low exactly while stalled; outputs 1..8 in order with no drop or duplicate.
- Mask op bypass: in_mask=1, vm=0, v0=0, op=111, vec0=vec1=0 → out_vec all-ones, out_mask=1.
- Reset flush: assert rst for 1 cycle with 3 requests in flight → out_valid stays 0 for the next LATENCY cycles.
- Op sweep: all 8 opSel values on random operands at SEW=8 with random v0 → match the reference model bitwise; out_sca and out_w_reg aligned with their requests.

Source files
------------

// File: rtl/vlogic_pkg.sv
// Shared encodings and types for the vector-logic pipeline: op codes, SEW codes,
// the SEW-to-bytes helper and the per-stage sideband flag bundle.
package vlogic_pkg;

   localparam logic [2:0] OP_ANDN = 3'b000;
   localparam logic [2:0] OP_AND  = 3'b001;
   localparam logic [2:0] OP_OR   = 3'b010;
   localparam logic [2:0] OP_XOR  = 3'b011;
   localparam logic [2:0] OP_ORN  = 3'b100;
   localparam logic [2:0] OP_NAND = 3'b101;
   localparam logic [2:0] OP_NOR  = 3'b110;
   localparam logic [2:0] OP_XNOR = 3'b111;

   typedef enum logic [1:0] {
      SEW_8  = 2'b00,
      SEW_16 = 2'b01,
      SEW_32 = 2'b10,
      SEW_64 = 2'b11
   } sew_t;

   function automatic int unsigned sew_bytes(input sew_t sew);
      return 32'd1 << sew;
   endfunction

   // Valid and sideband flags travel together so they can never drift apart.
   typedef struct packed {
      logic valid;
      logic sca;
      logic w_reg;
      logic mask;
   } pipe_flags_t;

endpackage

// File: rtl/vlogic_mask_expand.sv
// Expands per-element v0 mask bits into a per-byte enable vector for the
// selected element width. vm=1 enables every byte.
module vlogic_mask_expand
   import vlogic_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic [DATA_WIDTH/8-1:0] v0,
   input  sew_t                    sew,
   input  logic                    vm,
   output logic [DATA_WIDTH/8-1:0] byte_en
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int IW = $clog2(NB);

   // Byte b belongs to element b >> sew, so high v0 bits are never read at wide SEW.
   always_comb begin
      // NOTE: default first so every path assigns byte_en and no latch is inferred.
      byte_en = '0;
      for (int b = 0; b < NB; b++) begin
         logic [IW-1:0] elem;
         elem       = IW'(b >> sew);
         byte_en[b] = vm | v0[elem];
      end
   end

endmodule

// File: rtl/vlogic_pipe.sv
// Bitwise vector-logic lane: eight ops, SEW-aware v0 masking with undisturbed or
// agnostic fill, LATENCY-deep shift pipeline with a global output stall.
module vlogic_pipe
   import vlogic_pkg::*;
#(
   parameter int DATA_WIDTH      = 64,
   parameter int ADDR_WIDTH      = 32,
   parameter int LATENCY         = 6,
   parameter int OPSEL_WIDTH     = 3,
   parameter bit MASK_ENABLE     = 1'b1,
   parameter bit SIDEBAND_ENABLE = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [ADDR_WIDTH-1:0]   in_addr,
   input  logic [DATA_WIDTH-1:0]   in_vec0,
   input  logic [DATA_WIDTH-1:0]   in_vec1,
   input  logic [DATA_WIDTH-1:0]   in_vd_old,
   input  logic [DATA_WIDTH/8-1:0] in_v0,
   input  logic [OPSEL_WIDTH-1:0]  in_opSel,
   input  logic [1:0]              in_sew,
   input  logic                    in_vm,
   input  logic                    in_ma,
   input  logic                    in_sca,
   input  logic                    in_w_reg,
   input  logic                    in_mask,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH-1:0]   out_vec,
   output logic [ADDR_WIDTH-1:0]   out_addr,
   output logic                    out_sca,
   output logic                    out_w_reg,
   output logic                    out_mask
);

   localparam int NB = DATA_WIDTH / 8;

   typedef struct packed {
      logic                   valid;
      logic [ADDR_WIDTH-1:0]  addr;
      logic [DATA_WIDTH-1:0]  vec0;
      logic [DATA_WIDTH-1:0]  vec1;
      logic [DATA_WIDTH-1:0]  vd_old;
      logic [NB-1:0]          v0;
      logic [OPSEL_WIDTH-1:0] op;
      sew_t                   sew;
      logic                   vm;
      logic                   ma;
      logic                   sca;
      logic                   w_reg;
      logic                   mask;
   } req_t;

   typedef struct packed {
      pipe_flags_t           flags;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] vec;
   } entry_t;

   req_t              req_in;
   req_t              s0;
   entry_t            stage1_d;
   entry_t            pipe [1:LATENCY-1];
   logic [DATA_WIDTH-1:0] raw;
   logic [NB-1:0]     byte_en;
   logic              vm_eff;
   logic              stall;
   logic              accept;

   assign stall    = pipe[LATENCY-1].flags.valid & ~out_ready;
   assign in_ready = ~stall;
   assign accept   = in_valid & in_ready;

   // A non-accepted cycle enters as an all-zero bubble, which also gates the flags.
   always_comb begin
      req_in = '0;
      if (accept) begin
         req_in.valid  = 1'b1;
         req_in.addr   = in_addr;
         req_in.vec0   = in_vec0;
         req_in.vec1   = in_vec1;
         req_in.vd_old = in_vd_old;
         req_in.v0     = in_v0;
         req_in.op     = in_opSel;
         req_in.sew    = sew_t'(in_sew);
         req_in.vm     = in_vm;
         req_in.ma     = in_ma;
         req_in.sca    = in_sca;
         req_in.w_reg  = in_w_reg;
         req_in.mask   = in_mask;
      end
   end

   always_comb begin
      raw = '0;
      case (s0.op)
         OP_ANDN: if (MASK_ENABLE) raw = s0.vec0 & ~s0.vec1;
         OP_AND:  raw = s0.vec0 & s0.vec1;
         OP_OR:   raw = s0.vec0 | s0.vec1;
         OP_XOR:  raw = s0.vec0 ^ s0.vec1;
         OP_ORN:  if (MASK_ENABLE) raw = s0.vec0 | ~s0.vec1;
         OP_NAND: if (MASK_ENABLE) raw = ~(s0.vec0 & s0.vec1);
         OP_NOR:  if (MASK_ENABLE) raw = ~(s0.vec0 | s0.vec1);
         OP_XNOR: if (MASK_ENABLE) raw = ~(s0.vec0 ^ s0.vec1);
         default: raw = '0;
      endcase
   end

   assign vm_eff = s0.vm | s0.mask | ~MASK_ENABLE;

   vlogic_mask_expand #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mask_expand (
      .v0      (s0.v0),
      .sew     (s0.sew),
      .vm      (vm_eff),
      .byte_en (byte_en)
   );

   // Bubbles must stay all-zero here, otherwise ops like nand would turn them into ones.
   always_comb begin
      stage1_d = '0;
      if (s0.valid) begin
         stage1_d.flags = '{valid: 1'b1, sca: s0.sca, w_reg: s0.w_reg, mask: s0.mask};
         stage1_d.addr  = s0.addr;
         for (int b = 0; b < NB; b++) begin
            if (byte_en[b])
               stage1_d.vec[b*8 +: 8] = raw[b*8 +: 8];
            else if (s0.ma)
               stage1_d.vec[b*8 +: 8] = 8'hFF;
            else
               stage1_d.vec[b*8 +: 8] = s0.vd_old[b*8 +: 8];
         end
      end
   end

   // NOTE: every pipeline register is reset so a flush leaves no stale valid entry behind.
   always_ff @(posedge clk) begin
      if (rst) begin
         s0 <= '0;
         for (int i = 1; i < LATENCY; i++) pipe[i] <= '0;
      end else if (!stall) begin
         // NOTE: non-blocking assignments let every stage sample the pre-edge value of its predecessor.
         s0      <= req_in;
         pipe[1] <= stage1_d;
         for (int i = 2; i < LATENCY; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign out_valid = pipe[LATENCY-1].flags.valid;
   assign out_vec   = pipe[LATENCY-1].vec;
   assign out_addr  = pipe[LATENCY-1].addr;
   assign out_sca   = SIDEBAND_ENABLE & pipe[LATENCY-1].flags.sca;
   assign out_w_reg = SIDEBAND_ENABLE & pipe[LATENCY-1].flags.w_reg;
   assign out_mask  = SIDEBAND_ENABLE & pipe[LATENCY-1].flags.mask;

endmodule

// File: tb/tb_vlogic_pipe.sv
// Bench for vlogic_pipe: element-level reference model with a scoreboard checked
// on every output handshake, plus directed cases with hand-computed results.
module tb_vlogic_pipe;

   localparam int LATENCY = 6;

   typedef struct packed {
      logic [31:0] addr;
      logic [63:0] vec0;
      logic [63:0] vec1;
      logic [63:0] vd_old;
      logic [7:0]  v0;
      logic [2:0]  op;
      logic [1:0]  sew;
      logic        vm;
      logic        ma;
      logic        sca;
      logic        w_reg;
      logic        mask;
   } req_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [63:0] vec;
      logic        sca;
      logic        w_reg;
      logic        mask;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_addr = '0;
   logic [63:0] in_vec0 = '0, in_vec1 = '0, in_vd_old = '0;
   logic [7:0]  in_v0 = '0;
   logic [2:0]  in_opSel = '0;
   logic [1:0]  in_sew = '0;
   logic        in_vm = 1'b1, in_ma = 1'b0;
   logic        in_sca = 1'b0, in_w_reg = 1'b0, in_mask = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] out_vec;
   logic [31:0] out_addr;
   logic        out_sca, out_w_reg, out_mask;

   int n_tests = 0;
   int n_fail  = 0;
   exp_t        sb[$];
   logic [31:0] popped[$];

   always #5 clk = ~clk;

   vlogic_pipe #(
      .DATA_WIDTH (64), .ADDR_WIDTH (32), .LATENCY (LATENCY), .OPSEL_WIDTH (3),
      .MASK_ENABLE (1'b1), .SIDEBAND_ENABLE (1'b1)
   ) dut (
      .clk (clk), .rst (rst),
      .in_valid (in_valid), .in_ready (in_ready), .in_addr (in_addr),
      .in_vec0 (in_vec0), .in_vec1 (in_vec1), .in_vd_old (in_vd_old), .in_v0 (in_v0),
      .in_opSel (in_opSel), .in_sew (in_sew), .in_vm (in_vm), .in_ma (in_ma),
      .in_sca (in_sca), .in_w_reg (in_w_reg), .in_mask (in_mask),
      .out_valid (out_valid), .out_ready (out_ready), .out_vec (out_vec), .out_addr (out_addr),
      .out_sca (out_sca), .out_w_reg (out_w_reg), .out_mask (out_mask)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference: raw bitwise op, then overwrite each inactive element as a whole.
   function automatic exp_t model(input req_t r);
      exp_t        e;
      logic [63:0] a, b, raw, res, em;
      int          eb, ne;
      a  = r.vec0;
      b  = r.vec1;
      eb = 8 << r.sew;
      ne = 64 / eb;
      case (r.op)
         3'd0: raw = a & ~b;
         3'd1: raw = a & b;
         3'd2: raw = a | b;
         3'd3: raw = a ^ b;
         3'd4: raw = a | ~b;
         3'd5: raw = ~(a & b);
         3'd6: raw = ~(a | b);
         default: raw = ~(a ^ b);
      endcase
      res = raw;
      if (!r.mask && !r.vm) begin
         for (int i = 0; i < ne; i++) begin
            if (!r.v0[i]) begin
               em  = (eb == 64) ? '1 : (((64'd1 << eb) - 64'd1) << (i * eb));
               res = (res & ~em) | ((r.ma ? 64'hFFFF_FFFF_FFFF_FFFF : r.vd_old) & em);
            end
         end
      end
      e.addr  = r.addr;
      e.vec   = res;
      e.sca   = r.sca;
      e.w_reg = r.w_reg;
      e.mask  = r.mask;
      return e;
   endfunction

   function automatic req_t sample_in();
      req_t r;
      r = '{addr: in_addr, vec0: in_vec0, vec1: in_vec1, vd_old: in_vd_old, v0: in_v0,
            op: in_opSel, sew: in_sew, vm: in_vm, ma: in_ma, sca: in_sca,
            w_reg: in_w_reg, mask: in_mask};
      return r;
   endfunction

   // Scoreboard compare on every cycle away from the active edge.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
      end else begin
         check("in_ready_rule", in_ready, !(out_valid && !out_ready));
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("spurious_out_valid", out_valid, 1'b0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("sb_vec", out_vec, e.vec);
               check("sb_addr", out_addr, e.addr);
               check("sb_sca", out_sca, e.sca);
               check("sb_w_reg", out_w_reg, e.w_reg);
               check("sb_mask", out_mask, e.mask);
               popped.push_back(out_addr);
            end
         end
         if (in_valid && in_ready) sb.push_back(model(sample_in()));
      end
   end

   task automatic drive(input req_t r);
      in_addr = r.addr; in_vec0 = r.vec0; in_vec1 = r.vec1; in_vd_old = r.vd_old;
      in_v0 = r.v0; in_opSel = r.op; in_sew = r.sew; in_vm = r.vm; in_ma = r.ma;
      in_sca = r.sca; in_w_reg = r.w_reg; in_mask = r.mask;
   endtask

   // Holds the request until accepted; returns at posedge+1 with in_valid low.
   task automatic push_req(input req_t r);
      bit acc;
      drive(r);
      in_valid = 1'b1;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end while (!acc);
      in_valid = 1'b0;
   endtask

   // Single request into an empty pipe: checks latency and a literal result.
   task automatic send_wait(input string nm, input req_t r, input logic [63:0] lit);
      int cyc;
      @(posedge clk); #1;
      drive(r);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 1;
      @(negedge clk);
      while (!out_valid && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check({nm, "_latency"}, 64'(cyc), 64'(LATENCY));
      check({nm, "_vec"}, out_vec, lit);
      check({nm, "_addr"}, out_addr, r.addr);
      check({nm, "_mask"}, out_mask, r.mask);
   endtask

   task automatic drain();
      int cyc;
      cyc = 0;
      while ((sb.size() != 0 || out_valid) && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("drain_sb_empty", 64'(sb.size()), 64'd0);
   endtask

   function automatic req_t base_req();
      req_t r;
      r = '0;
      r.vm = 1'b1;
      return r;
   endfunction

   initial begin
      req_t r;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_vec", out_vec, 64'h0);
      check("rst_out_addr", out_addr, 64'h0);
      check("rst_flags", {out_sca, out_w_reg, out_mask}, 3'b000);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1'b1);

      // Unmasked and
      r = base_req();
      r.addr = 32'hCAFE_0001; r.vec0 = 64'hF0F0_F0F0_F0F0_F0F0; r.vec1 = 64'hFF00_FF00_FF00_FF00;
      r.op = 3'b001;
      send_wait("and_unmasked", r, 64'hF000_F000_F000_F000);
      drain();

      // SEW=16 masked or, undisturbed then agnostic
      r = base_req();
      r.addr = 32'h22; r.vm = 1'b0; r.v0 = 8'b0000_0101; r.sew = 2'b01;
      r.vd_old = 64'h1111_2222_3333_4444; r.vec1 = 64'hAAAA_BBBB_CCCC_DDDD; r.op = 3'b010;
      send_wait("or_sew16_mu", r, 64'h1111_BBBB_3333_DDDD);
      drain();
      r.ma = 1'b1; r.addr = 32'h23;
      send_wait("or_sew16_ma", r, 64'hFFFF_BBBB_FFFF_DDDD);
      drain();

      // Mask-register op bypasses v0
      r = base_req();
      r.addr = 32'h44; r.mask = 1'b1; r.vm = 1'b0; r.v0 = 8'h00; r.op = 3'b111;
      send_wait("mask_bypass", r, 64'hFFFF_FFFF_FFFF_FFFF);
      drain();

      // Backpressure: 8 back-to-back with a 3-cycle stall mid-stream
      popped.delete();
      @(posedge clk); #1;
      fork
         begin
            req_t q;
            for (int i = 1; i <= 8; i++) begin
               q = base_req();
               q.addr = 32'(i);
               q.vec0 = {$urandom, $urandom};
               q.vec1 = {$urandom, $urandom};
               q.op   = 3'(i);
               q.sca  = i[0];
               q.w_reg = i[1];
               push_req(q);
            end
         end
         begin
            repeat (7) @(posedge clk);
            #1 out_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               check("stall_in_ready_low", in_ready, 1'b0);
               check("stall_out_valid", out_valid, 1'b1);
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
            @(negedge clk);
            check("unstall_in_ready", in_ready, 1'b1);
         end
      join
      drain();
      check("bp_count", 64'(popped.size()), 64'd8);
      for (int i = 0; i < 8 && i < popped.size(); i++)
         check("bp_order", popped[i], 64'(i + 1));

      // Reset flush with 3 in flight
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         r = base_req();
         r.addr = 32'h100 + 32'(i); r.vec0 = 64'h1234; r.op = 3'b010;
         push_req(r);
      end
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      for (int k = 0; k < LATENCY; k++) begin
         @(negedge clk);
         check("flush_out_valid", out_valid, 1'b0);
         @(posedge clk);
         #1;
      end

      // Op sweep at SEW=8 with random v0, then a few wider SEWs
      for (int op = 0; op < 12; op++) begin
         r.addr   = 32'h200 + 32'(op);
         r.vec0   = {$urandom, $urandom};
         r.vec1   = {$urandom, $urandom};
         r.vd_old = {$urandom, $urandom};
         r.v0     = 8'($urandom);
         r.op     = 3'(op);
         r.sew    = (op < 8) ? 2'b00 : 2'(op - 8);
         r.vm     = 1'b0;
         r.ma     = 1'($urandom);
         r.sca    = 1'($urandom);
         r.w_reg  = 1'($urandom);
         r.mask   = 1'b0;
         push_req(r);
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
